// File: rtl/rtype_decode_stage.sv
// ---------------------------------------------------------------------------
// rtype_decode_stage
//
// Single registered decode stage for RV32 R-type (OP, opcode 0110011)
// instructions. Extracts register indices, maps funct7/funct3 to a 4-bit ALU
// operation code, flags unsupported words as illegal and keeps saturating
// statistics of decoded and illegal words leaving the stage.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous flush: drops the held word, blocks acceptance
//   in_valid     instruction word present
//   in_instr     32-bit instruction word
//   in_ready     stage can accept a word this cycle
//   out_valid    decoded fields valid
//   out_ready    downstream stage accepts the decoded word
//   rs1_addr     source register 1 index
//   rs2_addr     source register 2 index
//   rd_addr      destination register index
//   alu_op       ALU operation code (0000 for illegal words)
//   reg_write    legal word with rd != x0
//   illegal      word is not a supported R-type instruction
//   decoded_cnt  legal words handed downstream (saturating)
//   illegal_cnt  illegal words handed downstream (saturating)
// ---------------------------------------------------------------------------
module rtype_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_OP = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // ---------------- combinational decode of the incoming word (p0)
    logic [6:0] opcode_p0;
    logic [2:0] funct3_p0;
    logic [6:0] funct7_p0;
    logic [3:0] op_p0;
    logic       legal_p0;
    logic       rw_p0;

    assign opcode_p0 = in_instr[6:0];
    assign funct3_p0 = in_instr[14:12];
    assign funct7_p0 = in_instr[31:25];

    always_comb begin
        op_p0    = ALU_ADD;
        legal_p0 = 1'b0;
        if (opcode_p0 == OPC_OP) begin
            legal_p0 = 1'b1;
            case ({funct7_p0, funct3_p0})
                {7'b0000000, 3'b000}: op_p0 = ALU_ADD;
                {7'b0100000, 3'b000}: op_p0 = ALU_SUB;
                {7'b0000000, 3'b100}: op_p0 = ALU_XOR;
                {7'b0000000, 3'b110}: op_p0 = ALU_OR;
                {7'b0000000, 3'b111}: op_p0 = ALU_AND;
                {7'b0000000, 3'b001}: op_p0 = ALU_SLL;
                {7'b0000000, 3'b101}: op_p0 = ALU_SRL;
                {7'b0100000, 3'b101}: op_p0 = ALU_SRA;
                {7'b0000000, 3'b010}: op_p0 = ALU_SLT;
                {7'b0000000, 3'b011}: op_p0 = ALU_SLTU;
                default: begin
                    // Anything else (M extension, alt funct7 with other
                    // funct3, ...) is rejected with a neutral op code.
                    op_p0    = ALU_ADD;
                    legal_p0 = 1'b0;
                end
            endcase
        end
    end

    // Writes to x0 are architecturally discarded, so suppress them here.
    assign rw_p0 = legal_p0 && (in_instr[11:7] != 5'd0);

    // ---------------- handshake control
    logic vld_p1;
    logic accept;
    logic fire;

    assign in_ready = !flush && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = vld_p1 && out_ready;

    // ---------------- output register stage (p1)
    logic [4:0] rs1_p1;
    logic [4:0] rs2_p1;
    logic [4:0] rd_p1;
    logic [3:0] op_p1;
    logic       rw_p1;
    logic       ill_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            rd_p1  <= '0;
            op_p1  <= '0;
            rw_p1  <= 1'b0;
            ill_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            // Register indices are captured even for illegal words so the
            // downstream trap logic can report them.
            vld_p1 <= 1'b1;
            rs1_p1 <= in_instr[19:15];
            rs2_p1 <= in_instr[24:20];
            rd_p1  <= in_instr[11:7];
            op_p1  <= op_p0;
            rw_p1  <= rw_p0;
            ill_p1 <= !legal_p0;
        end else if (fire) begin
            vld_p1 <= 1'b0;
        end
    end

    // ---------------- statistics, counted on completed handshakes only
    logic [CNT_W-1:0] dec_cnt_p1;
    logic [CNT_W-1:0] ill_cnt_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_p1 <= '0;
            ill_cnt_p1 <= '0;
        end else if (fire && !flush) begin
            if (ill_p1) begin
                ill_cnt_p1 <= sat_inc(ill_cnt_p1);
            end else begin
                dec_cnt_p1 <= sat_inc(dec_cnt_p1);
            end
        end
    end

    assign out_valid   = vld_p1;
    assign rs1_addr    = rs1_p1;
    assign rs2_addr    = rs2_p1;
    assign rd_addr     = rd_p1;
    assign alu_op      = op_p1;
    assign reg_write   = rw_p1;
    assign illegal     = ill_p1;
    assign decoded_cnt = dec_cnt_p1;
    assign illegal_cnt = ill_cnt_p1;

endmodule

// File: tb/tb_rtype_decode_stage.sv
// Testbench for rtype_decode_stage: directed vectors, scoreboard queue filled
// on acceptance and drained by a monitor on output handshakes. A second
// instance built with CNT_W=4 shares the inputs to exercise saturation.
module tb_rtype_decode_stage;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] op;
        logic       ill;
        logic       rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, reg_write, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_op;
    logic [15:0] decoded_cnt, illegal_cnt;

    logic        in_ready4, out_valid4, reg_write4, illegal4;
    logic [4:0]  rs1_addr4, rs2_addr4, rd_addr4;
    logic [3:0]  alu_op4;
    logic [3:0]  decoded_cnt4, illegal_cnt4;

    rtype_decode_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .alu_op(alu_op), .reg_write(reg_write),
        .illegal(illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    rtype_decode_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_ready(out_ready), .rs1_addr(rs1_addr4), .rs2_addr(rs2_addr4),
        .rd_addr(rd_addr4), .alu_op(alu_op4), .reg_write(reg_write4),
        .illegal(illegal4), .decoded_cnt(decoded_cnt4), .illegal_cnt(illegal_cnt4)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errs = 0;
    exp_t q[$];
    exp_t cur_exp;
    logic [15:0] m_dec, m_ill;
    logic [3:0]  m_dec4, m_ill4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int rd, input int rs1, input int rs2,
                                input int op, input bit ill, input bit rw);
        exp_t e;
        e.rd  = 5'(rd);
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.op  = 4'(op);
        e.ill = ill;
        e.rw  = rw;
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    // Monitor + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_dec = '0; m_ill = '0; m_dec4 = '0; m_ill4 = '0;
        end else begin
            check("decoded_cnt", 32'(decoded_cnt), 32'(m_dec));
            check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
            check("decoded_cnt4", 32'(decoded_cnt4), 32'(m_dec4));
            check("illegal_cnt4", 32'(illegal_cnt4), 32'(m_ill4));
            if (out_valid && (out_ready || flush)) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_ready) begin
                        check("rd_addr", 32'(rd_addr), 32'(e.rd));
                        check("rs1_addr", 32'(rs1_addr), 32'(e.rs1));
                        check("rs2_addr", 32'(rs2_addr), 32'(e.rs2));
                        check("alu_op", 32'(alu_op), 32'(e.op));
                        check("illegal", 32'(illegal), 32'(e.ill));
                        check("reg_write", 32'(reg_write), 32'(e.rw));
                        if (!flush) begin
                            if (e.ill) begin
                                if (m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
                                if (m_ill4 != 4'hF) m_ill4 = m_ill4 + 4'd1;
                            end else begin
                                if (m_dec != 16'hFFFF) m_dec = m_dec + 16'd1;
                                if (m_dec4 != 4'hF) m_dec4 = m_dec4 + 4'd1;
                            end
                        end
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [31:0] instr, input exp_t e, input bit rnd, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        in_instr = instr;
        cur_exp  = e;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream table: all ten supported ops, hand-listed codes.
    logic [6:0] t_f7[10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0] t_f3[10] = '{3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
    int         t_op[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [20:0] held;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        cur_exp = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_decoded_cnt", 32'(decoded_cnt), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b1;
        #1;
        check("rst_flush_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // sub x10,x10,x11
        send(32'h40B50533, mk(10, 10, 11, 1, 0, 1), 0, n);
        check("sub_out_valid", 32'(out_valid), 32'd1);
        check("sub_alu_op", 32'(alu_op), 32'd1);
        check("sub_rd", 32'(rd_addr), 32'd10);
        check("sub_rs1", 32'(rs1_addr), 32'd10);
        check("sub_rs2", 32'(rs2_addr), 32'd11);
        check("sub_reg_write", 32'(reg_write), 32'd1);
        check("sub_illegal", 32'(illegal), 32'd0);
        tick();
        check("sub_decoded_cnt", 32'(decoded_cnt), 32'd1);
        check("sub_out_valid_clear", 32'(out_valid), 32'd0);

        // sra x1,x1,x2 held under backpressure
        out_ready = 1'b0;
        send(32'h4020D0B3, mk(1, 1, 2, 7, 0, 1), 0, n);
        check("sra_alu_op", 32'(alu_op), 32'd7);
        held = {rd_addr, rs1_addr, rs2_addr, alu_op, reg_write, illegal};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_fields", 32'({rd_addr, rs1_addr, rs2_addr, alu_op, reg_write, illegal}), 32'(held));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_decoded_cnt", 32'(decoded_cnt), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("sra_decoded_cnt", 32'(decoded_cnt), 32'd2);

        // addi and alt-funct7 xor: both illegal
        send(32'h00000013, mk(0, 0, 0, 0, 1, 0), 0, n);
        check("addi_illegal", 32'(illegal), 32'd1);
        check("addi_alu_op", 32'(alu_op), 32'd0);
        check("addi_reg_write", 32'(reg_write), 32'd0);
        send(32'h4020C0B3, mk(1, 1, 2, 0, 1, 0), 0, n);
        check("alt_xor_illegal", 32'(illegal), 32'd1);
        check("alt_xor_alu_op", 32'(alu_op), 32'd0);
        check("alt_xor_reg_write", 32'(reg_write), 32'd0);
        check("alt_xor_rd", 32'(rd_addr), 32'd1);
        tick();
        check("illegal_cnt_2", 32'(illegal_cnt), 32'd2);

        // add x0,x1,x2: legal but no write
        send(32'h00208033, mk(0, 1, 2, 0, 0, 0), 0, n);
        check("addx0_alu_op", 32'(alu_op), 32'd0);
        check("addx0_reg_write", 32'(reg_write), 32'd0);
        check("addx0_illegal", 32'(illegal), 32'd0);
        tick();
        check("addx0_decoded_cnt", 32'(decoded_cnt), 32'd3);

        // Ten legal words back to back
        for (int i = 0; i < 10; i++) begin
            send(enc(t_f7[i], 31 - i, i + 2, t_f3[i], i + 1), mk(i + 1, i + 2, 31 - i, t_op[i], 0, 1), 0, n);
            check("stream_cycles", 32'(n), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        tick();
        check("stream_decoded_cnt", 32'(decoded_cnt), 32'd13);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h40B50533;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_decoded_cnt", 32'(decoded_cnt), 32'd13);

        // Flush coinciding with a handshake must not count
        send(32'h40B50533, mk(10, 10, 11, 1, 0, 1), 0, n);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_hs_out_valid", 32'(out_valid), 32'd0);
        check("flush_hs_decoded_cnt", 32'(decoded_cnt), 32'd13);

        // Random backpressure stream plus two more illegal words
        for (int i = 0; i < 10; i++) begin
            send(enc(t_f7[i], i, 31 - i, t_f3[i], 20 + i), mk(20 + i, 31 - i, i, t_op[i], 0, 1), 1, n);
        end
        send(enc(7'h01, 2, 1, 3'd0, 3), mk(3, 1, 2, 0, 1, 0), 1, n);
        send({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0111011}, mk(3, 1, 2, 0, 1, 0), 1, n);
        out_ready = 1'b1;
        tick(); tick();
        check("final_decoded_cnt", 32'(decoded_cnt), 32'd23);
        check("final_illegal_cnt", 32'(illegal_cnt), 32'd4);
        check("sat_decoded_cnt4", 32'(decoded_cnt4), 32'hF);
        check("sat_illegal_cnt4", 32'(illegal_cnt4), 32'd4);

        // Asynchronous reset with a word held
        out_ready = 1'b0;
        send(32'h4020D0B3, mk(1, 1, 2, 7, 0, 1), 0, n);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_fields", 32'({rd_addr, rs1_addr, rs2_addr, alu_op, reg_write, illegal}), 32'd0);
        check("arst_decoded_cnt", 32'(decoded_cnt), 32'd0);
        check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        check("arst_decoded_cnt4", 32'(decoded_cnt4), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_decoded_cnt", 32'(decoded_cnt), 32'd0);
        tick();
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
